ssram_dma_engine: RTL and testbench
===================================

Name: ssram_dma_engine

Overview:
- Bus-master DMA engine that feeds port B of the 4-bank byte-offset SSRAM (the custom-instruction scratchpad).
- Moves blocks of 32-bit words between the system bus and the SSRAM in configurable bursts.
  - Direction 1 (bus-to-SSRAM) fills port B.
  - Direction 2 (SSRAM-to-bus) drains port B.
- The CPU configures and starts it through a small register interface driven by the custom-instruction decoder.
- Port A (byte-offset CPU access) is untouched by this block.

Parameters:
- bitwidth, 32, data width of bus and SSRAM port B.
- nrOfEntries, 640, SSRAM depth in words; SSRAM address width is $clog2(nrOfEntries).

Ports:
- clock  in  1  single system clock (also drives SSRAM clockB).
- reset  in  1  asynchronous, active-low reset.
- cfgWe  in  1  configuration write strobe.
- cfgSel  in  3  register select: 1 busStart, 2 memStart, 3 blockSize, 4 burstSize, 5 control, 6 status (read-only).
- cfgDataIn  in  32  configuration write data.
- cfgDataOut  out  32  combinational readback of the register selected by cfgSel.
- addressB  out  $clog2(nrOfEntries)  SSRAM port B address.
- writeEnableB  out  1  SSRAM port B write enable.
- dataInB  out  bitwidth  SSRAM port B write data.
- dataOutB  in  bitwidth  SSRAM port B read data; valid 1 cycle after its address.
- busRequest  out  1  bus arbitration request.
- busGrant  in  1  bus grant.
- beginTransaction  out  1  1-cycle transaction start.
- addressDataOut  out  32  address during begin, write data during beats.
- burstSize  out  8  beats-1 of the current burst.
- readNWrite  out  1  1 = bus read.
- dataValidOut  out  1  write beat valid.
- endTransactionOut  out  1  1-cycle end of write burst.
- addressDataIn  in  32  read data from bus.
- dataValidIn  in  1  read beat valid.
- endTransactionIn  in  1  slave ends a read burst.
- busyIn  in  1  slave stall; the current write beat is held.
- busErrorIn  in  1  bus error.

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; FSM goes to IDLE.
  - Registers cleared: busStart, memStart, blockSize, burstSize, control, error flag.
- Registers:
  - busStart[31:2]: word aligned; bits [1:0] read 0.
  - memStart: $clog2(nrOfEntries) bits.
  - blockSize: 10 bits, number of words.
  - burstSize: 8 bits, beats-1.
  - control: write 1 = start bus-to-SSRAM, 2 = start SSRAM-to-bus; other values are ignored.
- Status readback (sel 6): bit0 busy, bit1 error.
- Config writes while busy are ignored, except to status, which is read-only anyway.
- FSM states: IDLE, REQUEST, BEGIN, READ_BEATS, PREFETCH, WRITE_BEATS, END_WRITE, ERROR.
  - IDLE: on a valid control start with blockSize≠0:
    - latch working copies of busAddr, memAddr, remaining, direction;
    - go to REQUEST.
    - A start with blockSize=0 sets no state (busy stays 0).
  - REQUEST:
    - Hold busRequest=1 until busGrant.
    - On grant, compute beats = min(burstSize+1, remaining), then go to BEGIN.
  - BEGIN: one cycle with beginTransaction=1, addressDataOut=busAddr, burstSize=beats-1 and readNWrite set. Next state:
    - READ_BEATS when reading from the bus (bus-to-SSRAM);
    - PREFETCH when writing to the bus (SSRAM-to-bus).
  - READ_BEATS:
    - On each dataValidIn, in the same cycle: writeEnableB=1, addressB=memAddr, dataInB=addressDataIn.
    - After the beat: memAddr++, remaining--.
    - On endTransactionIn:
      - drop busRequest;
      - busAddr += 4*beats;
      - remaining≠0 → REQUEST, else → IDLE.
  - PREFETCH:
    - Drive addressB=memAddr for one cycle to read SSRAM, then go to WRITE_BEATS.
    - A one-word read-ahead buffer absorbs the 1-cycle SSRAM latency.
  - WRITE_BEATS:
    - dataValidOut=1 with the buffered word.
    - A beat is accepted when dataValidOut & !busyIn; data and address are held stable while busyIn=1.
    - After the last accepted beat → END_WRITE.
  - END_WRITE:
    - One cycle with endTransactionOut=1; busRequest drops.
    - remaining≠0 → REQUEST, else → IDLE.
  - ERROR:
    - Entered from any bus state on busErrorIn.
    - Set the error flag; drop all bus outputs and writeEnableB; return to IDLE next cycle.
    - The error flag clears on the next accepted start.
- memAddr wraps from nrOfEntries-1 to 0; busAddr wraps modulo 2^32.
- busy = (state≠IDLE).
- writeEnableB is only ever 1 in READ_BEATS with dataValidIn=1.
- An async reset mid-transfer aborts immediately with no completion pulse.

Test Plan:
- Bus-to-SSRAM, busStart=0x100, memStart=5, blockSize=8, burstSize=3, slave returns 0xA0..0xA7 → two bursts of 4 at bus 0x100 and 0x110; SSRAM words 5..12 = 0xA0..0xA7; busy falls after the second endTransactionIn.
- SSRAM-to-bus, memStart=0, blockSize=6, burstSize=3, SSRAM holds 0x10..0x15, busyIn high 2 cycles on beat 2 → bursts of 4 then 2; data 0x10..0x15 in order; beat 2 held stable during stall; endTransactionOut once per burst.
- Wrap: memStart=638, blockSize=4, bus-to-SSRAM → writes to addresses 638, 639, 0, 1.
- busErrorIn asserted on the 2nd read beat → status reads 0b10; busRequest=0 next cycle; only 1 SSRAM write occurred.
- Config write to busStart while busy → ignored; blockSize=0 start → busy stays 0.
- reset low mid-burst (async, between clock edges) → all outputs 0 immediately; status reads 0.

Source files
------------

// File: rtl/ssram_dma_engine_if.sv
// rtl/ssram_dma_engine_if.sv - config, SSRAM port B and system bus bundle for ssram_dma_engine
// Ports (master = DMA engine side):
//   config : cfgWe, cfgSel, cfgDataIn in; cfgDataOut out
//   SSRAM B: addressB, writeEnableB, dataInB out; dataOutB in
//   bus    : busRequest, beginTransaction, addressDataOut, burstSize, readNWrite,
//            dataValidOut, endTransactionOut out; busGrant, addressDataIn,
//            dataValidIn, endTransactionIn, busyIn, busErrorIn in
interface ssram_dma_engine_if #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 640
);
    localparam int AW = $clog2(nrOfEntries);

    logic                cfgWe;
    logic [2:0]          cfgSel;
    logic [31:0]         cfgDataIn;
    logic [31:0]         cfgDataOut;

    logic [AW-1:0]       addressB;
    logic                writeEnableB;
    logic [bitwidth-1:0] dataInB;
    logic [bitwidth-1:0] dataOutB;

    logic                busRequest;
    logic                busGrant;
    logic                beginTransaction;
    logic [31:0]         addressDataOut;
    logic [7:0]          burstSize;
    logic                readNWrite;
    logic                dataValidOut;
    logic                endTransactionOut;
    logic [31:0]         addressDataIn;
    logic                dataValidIn;
    logic                endTransactionIn;
    logic                busyIn;
    logic                busErrorIn;

    modport master (
        input  cfgWe, cfgSel, cfgDataIn,
        output cfgDataOut,
        output addressB, writeEnableB, dataInB,
        input  dataOutB,
        output busRequest, beginTransaction, addressDataOut, burstSize, readNWrite,
        output dataValidOut, endTransactionOut,
        input  busGrant, addressDataIn, dataValidIn, endTransactionIn, busyIn, busErrorIn
    );

    modport slave (
        output cfgWe, cfgSel, cfgDataIn,
        input  cfgDataOut,
        input  addressB, writeEnableB, dataInB,
        output dataOutB,
        input  busRequest, beginTransaction, addressDataOut, burstSize, readNWrite,
        input  dataValidOut, endTransactionOut,
        output busGrant, addressDataIn, dataValidIn, endTransactionIn, busyIn, busErrorIn
    );
endinterface

// File: rtl/ssram_dma_engine.sv
// rtl/ssram_dma_engine.sv - bus-master DMA between system bus and SSRAM port B
// Ports: clock (system clock, also SSRAM clockB), reset (async active-low),
//        bus (ssram_dma_engine_if.master: config registers, SSRAM port B, system bus).
module ssram_dma_engine #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 640
) (
    input  logic               clock,
    input  logic               reset,
    ssram_dma_engine_if.master bus
);
    localparam int AW = $clog2(nrOfEntries);
    localparam logic [AW-1:0] LAST_ENTRY = AW'(nrOfEntries - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_BEGIN, S_READ_BEATS,
        S_PREFETCH, S_WRITE_BEATS, S_END_WRITE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [29:0]         bus_start_q, bus_start_d;
    logic [AW-1:0]       mem_start_q, mem_start_d;
    logic [9:0]          block_size_q, block_size_d;
    logic [7:0]          burst_cfg_q, burst_cfg_d;
    logic [1:0]          control_q, control_d;
    logic                err_q, err_d;
    logic [31:0]         bus_addr_q, bus_addr_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [9:0]          remaining_q, remaining_d;
    logic                dir_rd_q, dir_rd_d;      // 1 = bus-to-SSRAM
    logic [8:0]          beats_q, beats_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic                fresh_q, fresh_d;        // dataOutB holds a word addressed last cycle
    logic [bitwidth-1:0] rd_buf_q, rd_buf_d;

    logic [AW-1:0]       next_mem;
    logic [bitwidth-1:0] data_word;
    logic [9:0]          burst_p1;
    logic                busy, start_ok;

    logic [31:0]         cfg_out;
    logic [AW-1:0]       addr_b;
    logic                we_b, req, begin_t, rnw, dvo, endw;
    logic [bitwidth-1:0] din_b;
    logic [31:0]         ad_out;
    logic [7:0]          bsz;

    assign bus.cfgDataOut        = cfg_out;
    assign bus.addressB          = addr_b;
    assign bus.writeEnableB      = we_b;
    assign bus.dataInB           = din_b;
    assign bus.busRequest        = req;
    assign bus.beginTransaction  = begin_t;
    assign bus.addressDataOut    = ad_out;
    assign bus.burstSize         = bsz;
    assign bus.readNWrite        = rnw;
    assign bus.dataValidOut      = dvo;
    assign bus.endTransactionOut = endw;

    always_comb begin
        state_d      = state_q;
        bus_start_d  = bus_start_q;
        mem_start_d  = mem_start_q;
        block_size_d = block_size_q;
        burst_cfg_d  = burst_cfg_q;
        control_d    = control_q;
        err_d        = err_q;
        bus_addr_d   = bus_addr_q;
        mem_addr_d   = mem_addr_q;
        remaining_d  = remaining_q;
        dir_rd_d     = dir_rd_q;
        beats_d      = beats_q;
        beat_cnt_d   = beat_cnt_q;
        fresh_d      = 1'b0;
        rd_buf_d     = rd_buf_q;

        addr_b  = '0;
        we_b    = 1'b0;
        din_b   = '0;
        req     = 1'b0;
        begin_t = 1'b0;
        ad_out  = '0;
        bsz     = '0;
        rnw     = 1'b0;
        dvo     = 1'b0;
        endw    = 1'b0;

        busy      = (state_q != S_IDLE);
        next_mem  = (mem_addr_q == LAST_ENTRY) ? '0 : mem_addr_q + 1'b1;
        data_word = fresh_q ? bus.dataOutB : rd_buf_q;
        burst_p1  = {2'b00, burst_cfg_q} + 10'd1;
        start_ok  = bus.cfgWe && (bus.cfgSel == 3'd5) && (block_size_q != 10'd0) &&
                    ((bus.cfgDataIn == 32'd1) || (bus.cfgDataIn == 32'd2));

        case (bus.cfgSel)
            3'd1:    cfg_out = {bus_start_q, 2'b00};
            3'd2:    cfg_out = 32'(mem_start_q);
            3'd3:    cfg_out = 32'(block_size_q);
            3'd4:    cfg_out = 32'(burst_cfg_q);
            3'd5:    cfg_out = 32'(control_q);
            3'd6:    cfg_out = {30'd0, err_q, busy};
            default: cfg_out = '0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.cfgWe) begin
                    case (bus.cfgSel)
                        3'd1:    bus_start_d  = bus.cfgDataIn[31:2];
                        3'd2:    mem_start_d  = bus.cfgDataIn[AW-1:0];
                        3'd3:    block_size_d = bus.cfgDataIn[9:0];
                        3'd4:    burst_cfg_d  = bus.cfgDataIn[7:0];
                        default: ;
                    endcase
                end
                if (start_ok) begin
                    control_d   = bus.cfgDataIn[1:0];
                    err_d       = 1'b0;
                    bus_addr_d  = {bus_start_q, 2'b00};
                    mem_addr_d  = mem_start_q;
                    remaining_d = block_size_q;
                    dir_rd_d    = (bus.cfgDataIn[1:0] == 2'd1);
                    state_d     = S_REQUEST;
                end
            end
            S_REQUEST: begin
                req = 1'b1;
                if (bus.busGrant) begin
                    // remaining never exceeds burst_p1 (<= 256) on the else side
                    beats_d = (burst_p1 < remaining_q) ? burst_p1[8:0] : remaining_q[8:0];
                    state_d = S_BEGIN;
                end
            end
            S_BEGIN: begin
                req     = 1'b1;
                begin_t = 1'b1;
                ad_out  = bus_addr_q;
                bsz     = 8'(beats_q - 9'd1);
                rnw     = dir_rd_q;
                state_d = dir_rd_q ? S_READ_BEATS : S_PREFETCH;
            end
            S_READ_BEATS: begin
                req = 1'b1;
                if (bus.dataValidIn) begin
                    we_b        = 1'b1;
                    addr_b      = mem_addr_q;
                    din_b       = bus.addressDataIn[bitwidth-1:0];
                    mem_addr_d  = next_mem;
                    remaining_d = remaining_q - 10'd1;
                end
                if (bus.endTransactionIn) begin
                    req        = 1'b0;
                    bus_addr_d = bus_addr_q + {21'd0, beats_q, 2'b00};
                    state_d    = (remaining_d != 10'd0) ? S_REQUEST : S_IDLE;
                end
            end
            S_PREFETCH: begin
                req        = 1'b1;
                addr_b     = mem_addr_q;
                mem_addr_d = next_mem;
                fresh_d    = 1'b1;
                beat_cnt_d = beats_q;
                state_d    = S_WRITE_BEATS;
            end
            S_WRITE_BEATS: begin
                req      = 1'b1;
                addr_b   = mem_addr_q;
                dvo      = 1'b1;
                ad_out   = 32'(data_word);
                rd_buf_d = data_word;
                if (!bus.busyIn) begin
                    remaining_d = remaining_q - 10'd1;
                    beat_cnt_d  = beat_cnt_q - 9'd1;
                    if (beat_cnt_q == 9'd1) begin
                        state_d = S_END_WRITE;
                    end else begin
                        // read ahead the next word so it arrives with the next beat
                        mem_addr_d = next_mem;
                        fresh_d    = 1'b1;
                    end
                end
            end
            S_END_WRITE: begin
                endw       = 1'b1;
                bus_addr_d = bus_addr_q + {21'd0, beats_q, 2'b00};
                state_d    = (remaining_q != 10'd0) ? S_REQUEST : S_IDLE;
            end
            S_ERROR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a bus error overrides any bus-phase decision, including a beat seen this cycle
        if (busy && (state_q != S_ERROR) && bus.busErrorIn) begin
            we_b    = 1'b0;
            state_d = S_ERROR;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bus_start_q  <= '0;
            mem_start_q  <= '0;
            block_size_q <= '0;
            burst_cfg_q  <= '0;
            control_q    <= '0;
            err_q        <= 1'b0;
            bus_addr_q   <= '0;
            mem_addr_q   <= '0;
            remaining_q  <= '0;
            dir_rd_q     <= 1'b0;
            beats_q      <= '0;
            beat_cnt_q   <= '0;
            fresh_q      <= 1'b0;
            rd_buf_q     <= '0;
        end else begin
            state_q      <= state_d;
            bus_start_q  <= bus_start_d;
            mem_start_q  <= mem_start_d;
            block_size_q <= block_size_d;
            burst_cfg_q  <= burst_cfg_d;
            control_q    <= control_d;
            err_q        <= err_d;
            bus_addr_q   <= bus_addr_d;
            mem_addr_q   <= mem_addr_d;
            remaining_q  <= remaining_d;
            dir_rd_q     <= dir_rd_d;
            beats_q      <= beats_d;
            beat_cnt_q   <= beat_cnt_d;
            fresh_q      <= fresh_d;
            rd_buf_q     <= rd_buf_d;
        end
    end
endmodule

// File: tb/tb_ssram_dma_engine.sv
// tb/tb_ssram_dma_engine.sv - self-checking bench for ssram_dma_engine
module tb_ssram_dma_engine;
    localparam int BW = 32;
    localparam int NE = 640;
    localparam int AW = $clog2(NE);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ssram_dma_engine_if #(.bitwidth(BW), .nrOfEntries(NE)) dif ();
    ssram_dma_engine #(.bitwidth(BW), .nrOfEntries(NE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.master)
    );

    // SSRAM port B model with a preload port used while the engine is idle
    logic [BW-1:0] mem [NE];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [BW-1:0] pre_data = '0;
    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (dif.writeEnableB) mem[dif.addressB] <= dif.dataInB;
        dif.dataOutB <= mem[dif.addressB];
    end

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] bsz; logic rnw; } bg_t;
    typedef struct { logic we; logic [2:0] sel; logic [31:0] wd; logic [31:0] exp; } cfg_vec_t;

    wr_t         wq[$];
    bg_t         bq[$];
    logic [31:0] dq[$];
    int n_cmp = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_endw = 0;
    int maddr;
    logic [31:0] rd;
    cfg_vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [31:0] data);
        dif.cfgWe = 1'b1;
        dif.cfgSel = sel;
        dif.cfgDataIn = data;
        tick();
        dif.cfgWe = 1'b0;
    endtask

    task automatic cfg_check(input string name, input logic [2:0] sel, input logic [31:0] exp);
        dif.cfgSel = sel;
        #1;
        check(name, dif.cfgDataOut, exp);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_busRequest"}, dif.busRequest, 0);
        check({pfx, "_writeEnableB"}, dif.writeEnableB, 0);
        check({pfx, "_beginTransaction"}, dif.beginTransaction, 0);
        check({pfx, "_dataValidOut"}, dif.dataValidOut, 0);
        check({pfx, "_endTransactionOut"}, dif.endTransactionOut, 0);
        check({pfx, "_addressB"}, 32'(dif.addressB), 0);
        check({pfx, "_addressDataOut"}, dif.addressDataOut, 0);
        check({pfx, "_burstSize"}, 32'(dif.burstSize), 0);
        check({pfx, "_readNWrite"}, dif.readNWrite, 0);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40; i++) begin
            if (dif.busRequest) break;
            tick();
        end
        check(name, dif.busRequest, 1);
    endtask

    // Bus slave for a read burst; err_beat < 0 means no error
    task automatic read_burst(input int nbeats, input logic [31:0] baddr, input logic [31:0] data0,
                              inout int ma, input int err_beat, input int grant_delay);
        wait_req("rd_request");
        for (int i = 0; i < grant_delay; i++) begin
            tick();
            check("rd_request_held", dif.busRequest, 1);
        end
        bq.push_back('{addr: baddr, bsz: 8'(nbeats - 1), rnw: 1'b1});
        dif.busGrant = 1'b1;
        tick();
        dif.busGrant = 1'b0;
        tick();
        for (int b = 0; b < nbeats; b++) begin
            dif.dataValidIn = 1'b1;
            dif.addressDataIn = data0 + 32'(b);
            dif.endTransactionIn = (b == nbeats - 1);
            if (b == err_beat) begin
                dif.busErrorIn = 1'b1;
            end else begin
                wq.push_back('{addr: AW'(ma), data: data0 + 32'(b)});
                ma = (ma + 1) % NE;
            end
            tick();
            dif.dataValidIn = 1'b0;
            dif.endTransactionIn = 1'b0;
            dif.busErrorIn = 1'b0;
            if (b == err_beat) break;
        end
    endtask

    // Bus slave for a write burst; stalls stall_cycles on accepted-beat index stall_beat
    task automatic write_burst(input int nbeats, input logic [31:0] baddr,
                               input int stall_beat, input int stall_cycles);
        logic [31:0] held;
        int acc;
        int st;
        int guard;
        acc = 0;
        st = 0;
        guard = 0;
        held = '0;
        wait_req("wr_request");
        bq.push_back('{addr: baddr, bsz: 8'(nbeats - 1), rnw: 1'b0});
        dif.busGrant = 1'b1;
        tick();
        dif.busGrant = 1'b0;
        tick();
        tick();
        while (acc < nbeats && guard < 60) begin
            check("wr_valid", dif.dataValidOut, 1);
            if (acc == stall_beat && st < stall_cycles) begin
                dif.busyIn = 1'b1;
                if (st == 0) held = dif.addressDataOut;
                else check("stall_hold", dif.addressDataOut, held);
                st++;
            end else begin
                dif.busyIn = 1'b0;
                if (acc == stall_beat && stall_cycles > 0) check("stall_release", dif.addressDataOut, held);
                acc++;
            end
            tick();
            guard++;
        end
        dif.busyIn = 1'b0;
        check("wr_beats_done", acc, nbeats);
        check("endw_pulse", dif.endTransactionOut, 1);
        check("endw_req_drop", dif.busRequest, 0);
        tick();
    endtask

    task automatic monitor();
        wr_t w;
        bg_t b;
        logic [31:0] d;
        forever begin
            @(negedge clock);
            if (dif.writeEnableB) begin
                n_wr++;
                check("ssram_write_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("ssram_addr", 32'(dif.addressB), 32'(w.addr));
                    check("ssram_data", dif.dataInB, w.data);
                end
            end
            if (dif.beginTransaction) begin
                check("begin_expected", 32'(bq.size() != 0), 1);
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    check("begin_addr", dif.addressDataOut, b.addr);
                    check("begin_burst", 32'(dif.burstSize), 32'(b.bsz));
                    check("begin_rnw", dif.readNWrite, b.rnw);
                end
            end
            if (dif.dataValidOut && !dif.busyIn) begin
                check("wr_beat_expected", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    check("wr_beat_data", dif.addressDataOut, d);
                end
            end
            if (dif.endTransactionOut) n_endw++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        dif.cfgWe = 0; dif.cfgSel = 0; dif.cfgDataIn = 0;
        dif.busGrant = 0; dif.addressDataIn = 0; dif.dataValidIn = 0;
        dif.endTransactionIn = 0; dif.busyIn = 0; dif.busErrorIn = 0;
        fork
            monitor();
        join_none
        tick();
        tick();
        check_outputs_zero("reset");
        reset = 1'b1;
        tick();

        // register table: reset values, masking, ignored writes, zero-length start
        vecs = '{
            '{1'b0, 3'd1, 32'h0,         32'h0},
            '{1'b0, 3'd2, 32'h0,         32'h0},
            '{1'b0, 3'd3, 32'h0,         32'h0},
            '{1'b0, 3'd4, 32'h0,         32'h0},
            '{1'b0, 3'd5, 32'h0,         32'h0},
            '{1'b0, 3'd6, 32'h0,         32'h0},
            '{1'b1, 3'd1, 32'h12345677,  32'h12345674},
            '{1'b1, 3'd2, 32'h00001234,  32'h00000234},
            '{1'b1, 3'd4, 32'h000001FF,  32'h000000FF},
            '{1'b1, 3'd3, 32'h00000000,  32'h00000000},
            '{1'b1, 3'd5, 32'h00000001,  32'h00000000},
            '{1'b0, 3'd6, 32'h0,         32'h0},
            '{1'b1, 3'd3, 32'h00000FFF,  32'h000003FF},
            '{1'b1, 3'd5, 32'h00000003,  32'h00000000},
            '{1'b1, 3'd6, 32'hFFFFFFFF,  32'h00000000},
            '{1'b1, 3'd0, 32'hFFFFFFFF,  32'h00000000}
        };
        foreach (vecs[i]) begin
            if (vecs[i].we) cfg_write(vecs[i].sel, vecs[i].wd);
            cfg_check($sformatf("cfg_vec%0d", i), vecs[i].sel, vecs[i].exp);
        end
        check_outputs_zero("idle");

        // bus-to-SSRAM, two bursts of 4
        cfg_write(1, 32'h100); cfg_write(2, 5); cfg_write(3, 8); cfg_write(4, 3);
        n_wr = 0;
        maddr = 5;
        cfg_write(5, 1);
        cfg_check("t1_status_busy", 6, 32'h1);
        read_burst(4, 32'h100, 32'hA0, maddr, -1, 2);
        read_burst(4, 32'h110, 32'hA4, maddr, -1, 0);
        check("t1_req_low", dif.busRequest, 0);
        cfg_check("t1_status_idle", 6, 32'h0);
        check("t1_nwrites", n_wr, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t1_mem%0d", 5 + i), mem[5 + i], 32'hA0 + 32'(i));

        // SSRAM-to-bus, bursts of 4 and 2, stall on the second beat
        tick();
        for (int i = 0; i < 6; i++) begin
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = 32'h10 + 32'(i);
            tick();
        end
        pre_we = 1'b0;
        cfg_write(1, 32'h200); cfg_write(2, 0); cfg_write(3, 6);
        for (int i = 0; i < 6; i++) dq.push_back(32'h10 + 32'(i));
        n_endw = 0;
        cfg_write(5, 2);
        write_burst(4, 32'h200, 1, 2);
        write_burst(2, 32'h210, -1, 0);
        cfg_check("t2_status_idle", 6, 32'h0);
        check("t2_endw_count", n_endw, 2);
        check("t2_dq_empty", dq.size(), 0);

        // address wrap at the top of the SSRAM
        cfg_write(1, 32'h300); cfg_write(2, 638); cfg_write(3, 4);
        n_wr = 0;
        maddr = 638;
        cfg_write(5, 1);
        read_burst(4, 32'h300, 32'hC0, maddr, -1, 0);
        check("t3_mem638", mem[638], 32'hC0);
        check("t3_mem639", mem[639], 32'hC1);
        check("t3_mem0", mem[0], 32'hC2);
        check("t3_mem1", mem[1], 32'hC3);
        check("t3_nwrites", n_wr, 4);

        // bus error on the second read beat
        cfg_write(1, 32'h400); cfg_write(2, 20); cfg_write(3, 4);
        n_wr = 0;
        maddr = 20;
        cfg_write(5, 1);
        read_burst(4, 32'h400, 32'hE0, maddr, 1, 0);
        check("t4_req_drop", dif.busRequest, 0);
        check("t4_we_drop", dif.writeEnableB, 0);
        tick();
        cfg_check("t4_status_err", 6, 32'h2);
        check("t4_nwrites", n_wr, 1);

        // config write while busy ignored; start clears error; zero-length start
        cfg_write(1, 32'h500); cfg_write(2, 30); cfg_write(3, 2);
        maddr = 30;
        cfg_write(5, 1);
        cfg_check("t5_status_busy", 6, 32'h1);
        cfg_write(1, 32'hDEAD0000);
        read_burst(2, 32'h500, 32'h50, maddr, -1, 0);
        cfg_check("t5_busstart_kept", 1, 32'h500);
        cfg_check("t5_status_idle", 6, 32'h0);
        tick();
        cfg_write(3, 0);
        cfg_write(5, 1);
        cfg_check("t5_zero_len_idle", 6, 32'h0);
        check("t5_zero_len_req", dif.busRequest, 0);

        // async reset in the middle of a read burst
        tick();
        cfg_write(1, 32'h600); cfg_write(2, 40); cfg_write(3, 4);
        cfg_write(5, 1);
        wait_req("t6_request");
        bq.push_back('{addr: 32'h600, bsz: 8'd3, rnw: 1'b1});
        dif.busGrant = 1'b1;
        tick();
        dif.busGrant = 1'b0;
        tick();
        wq.push_back('{addr: AW'(40), data: 32'h77});
        dif.dataValidIn = 1'b1; dif.addressDataIn = 32'h77;
        tick();
        dif.addressDataIn = 32'h78;
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("t6_midreset");
        cfg_check("t6_status", 6, 32'h0);
        dif.dataValidIn = 1'b0;
        tick();
        reset = 1'b1;
        cfg_check("t6_busstart_cleared", 1, 32'h0);

        check("final_wq_empty", wq.size(), 0);
        check("final_bq_empty", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
